sw_debounce: RTL and testbench

Per-bit synchronizer and debouncer for the board slide switches. It sits directly upstream of the switch/LED xbus peripheral and drives that block's 8-bit `sw` input with clean, glitch-free levels. It also produces a one-cycle change pulse per bit for use as an interrupt or event source. There is no bus interface: raw pins in, debounced levels and pulses out.

---
 rtl/sw_debounce.sv | 65 ++++++
 tb/tb_sw_debounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch synchronizer and debouncer with change pulses
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            s1_q, s2_q;
    logic [WIDTH-1:0]            stb_q, stb_d;
    logic [WIDTH-1:0]            chg_q, chg_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        any_q, any_d;

    // A bit is accepted only after s2 disagrees with stb for DEBOUNCE_CYCLES
    // consecutive edges; any agreement in between restarts the count.
    always_comb begin
        stb_d = stb_q;
        chg_d = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == stb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stb_d[i] = s2_q[i];
                cnt_d[i] = '0;
                chg_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        any_d = |chg_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            stb_q <= '0;
            chg_q <= '0;
            cnt_q <= '0;
            any_q <= 1'b0;
        end else begin
            s1_q  <= sw_raw;
            s2_q  <= s1_q;
            stb_q <= stb_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
            any_q <= any_d;
        end
    end

    assign sw          = stb_q;
    assign sw_changed  = chg_q;
    assign any_changed = any_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] raw4, raw1;
    logic [7:0] sw4, chg4, sw1, chg1;
    logic       any4, any1;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses;
    int bad;

    sw_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(D)) dut4 (
        .clk(clk), .rst_n(rst_n), .sw_raw(raw4),
        .sw(sw4), .sw_changed(chg4), .any_changed(any4)
    );

    sw_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_raw(raw1),
        .sw(sw1), .sw_changed(chg1), .any_changed(any1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        raw4  = 8'h00;
        raw1  = 8'h00;
        #2;
        check("reset_sw", 32'(sw4), 32'h00);
        check("reset_chg", 32'(chg4), 32'h00);
        check("reset_any", 32'(any4), 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // clean rise: update at edge k+D+1
        raw4 = 8'h01;
        repeat (D + 1) tick();
        check("rise_before", 32'(sw4), 32'h00);
        tick();
        check("rise_sw", 32'(sw4), 32'h01);
        check("rise_chg", 32'(chg4), 32'h01);
        check("rise_any", 32'(any4), 32'h1);
        tick();
        check("rise_chg_clear", 32'(chg4), 32'h00);
        check("rise_any_clear", 32'(any4), 32'h0);
        check("rise_hold", 32'(sw4), 32'h01);

        // glitch on bit 3 shorter than D
        raw4 = 8'h09;
        repeat (3) tick();
        raw4 = 8'h01;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sw4 != 8'h01 || chg4 != 8'h00 || any4) bad++;
        end
        check("glitch_rejected", 32'(bad), 32'd0);

        // fall back to zero
        raw4 = 8'h00;
        repeat (D + 2) tick();
        check("fall_sw", 32'(sw4), 32'h00);
        check("fall_chg", 32'(chg4), 32'h01);
        repeat (4) tick();

        // bounce 1,0,1,0,1 then hold 1
        raw4 = 8'h01; tick();
        raw4 = 8'h00; tick();
        raw4 = 8'h01; tick();
        raw4 = 8'h00; tick();
        raw4 = 8'h01;
        pulses = 0;
        bad = 0;
        for (int i = 0; i < D + 1; i++) begin
            tick();
            if (chg4[0]) pulses++;
            if (sw4[0]) bad++;
        end
        check("bounce_early", 32'(bad), 32'd0);
        tick();
        check("bounce_sw", 32'(sw4), 32'h01);
        check("bounce_chg", 32'(chg4), 32'h01);
        if (chg4[0]) pulses++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (chg4[0]) pulses++;
        end
        check("bounce_one_pulse", 32'(pulses), 32'd1);

        raw4 = 8'h00;
        repeat (D + 6) tick();

        // multi-bit rise then fall
        raw4 = 8'hA5;
        repeat (D + 1) tick();
        check("multi_before", 32'(sw4), 32'h00);
        tick();
        check("multi_sw", 32'(sw4), 32'hA5);
        check("multi_chg", 32'(chg4), 32'hA5);
        tick();
        check("multi_chg_clear", 32'(chg4), 32'h00);
        repeat (5) tick();
        raw4 = 8'h00;
        repeat (D + 1) tick();
        check("multi_fall_before", 32'(sw4), 32'hA5);
        tick();
        check("multi_fall_sw", 32'(sw4), 32'h00);
        check("multi_fall_chg", 32'(chg4), 32'hA5);
        check("multi_fall_any", 32'(any4), 32'h1);
        repeat (4) tick();

        // reset asserted mid-count
        raw4 = 8'hFF;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_sw", 32'(sw4), 32'h00);
        check("rst_mid_chg", 32'(chg4), 32'h00);
        check("rst_mid_any", 32'(any4), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (D + 1) tick();
        check("rst_rel_before", 32'(sw4), 32'h00);
        tick();
        check("rst_rel_sw", 32'(sw4), 32'hFF);
        check("rst_rel_chg", 32'(chg4), 32'hFF);

        // DEBOUNCE_CYCLES=1: k+2 latency, single-cycle level passes
        repeat (3) tick();
        raw1 = 8'h01;
        tick();
        tick();
        check("d1_before", 32'(sw1), 32'h00);
        tick();
        check("d1_sw", 32'(sw1), 32'h01);
        check("d1_any", 32'(any1), 32'h1);
        repeat (3) tick();
        raw1 = 8'h03;
        tick();
        raw1 = 8'h01;
        tick();
        tick();
        check("d1_pulse_high", 32'(sw1), 32'h03);
        tick();
        check("d1_pulse_low", 32'(sw1), 32'h01);
        check("d1_pulse_chg", 32'(chg1), 32'h02);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
